count_monitor: RTL and testbench
================================

Name: count_monitor

Overview:
- Downstream consumer of the 4-bit synchronous up-counter output; samples `count` every qualified clock and checks that the sequence is legal.
- Legal sequence is +1 per step, with wrap from max to 0.
- Reports wrap events, sequence errors and lock status.
- Used as an on-chip checker / self-test stage behind the counter and as a rollover source for cascaded stages.

Parameters:
- WIDTH, 4, width of the monitored count.
- WRAP_W, 8, width of the wrap-event counter (saturating).
- ERR_LIMIT, 3, consecutive sequence errors that force FAULT (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- count  input  WIDTH  counter value under observation.
- count_vld  input  1  count is sampled on this cycle when high.
- clr  input  1  synchronous soft clear of statistics and state.
- wrap_pulse  output  1  one-cycle pulse on legal max->0 transition.
- err_pulse  output  1  one-cycle pulse on illegal transition.
- wrap_cnt  output  WRAP_W  number of legal wraps, saturates at all-ones.
- err_cnt  output  4  number of illegal transitions, saturates at 15.
- locked  output  1  high while in TRACK.
- state  output  2  00 INIT, 01 TRACK, 10 FAULT.

Behaviour:
- Reset (reset==0 at rising clk):
  - state=INIT, locked=0, wrap_pulse=0, err_pulse=0, wrap_cnt=0, err_cnt=0.
  - Internal prev=0, consec_err=0.
  - Reset has priority over clr and count_vld.
- clr==1 (reset high): same clearing as reset; the sample on that cycle is discarded.
- count_vld==0: state, prev and counters hold; pulses are 0.
- All outputs are registered. Pulses assert in the cycle after the sampling edge, last exactly one cycle, and never assert together.
- expected = (prev + 1) mod 2^WIDTH; max = 2^WIDTH-1.
- INIT, on a valid sample: prev<=count, go TRACK, locked=1 next cycle. No pulse for the first sample.
- TRACK, on a valid sample, first matching rule wins:
  - count==prev (hold, upstream stalled): no pulse, no change.
  - count==expected and prev==max: wrap_pulse, wrap_cnt+1 (saturating), consec_err<=0.
  - count==expected otherwise: no pulse, consec_err<=0.
  - anything else: err_pulse, err_cnt+1 (saturating), consec_err+1. If the new consec_err==ERR_LIMIT, go FAULT and set locked=0.
  - prev<=count on every valid sample in all TRACK cases.
- FAULT:
  - On a valid sample with count==0: prev<=0, consec_err<=0, go TRACK. This models the upstream counter being reset.
  - Any other valid sample: prev<=count, no pulses, no counter change.
- Reset or clr mid-sequence: returns to INIT; the next valid sample re-seeds prev without an error.
- Counter saturation: wrap_cnt at all-ones and err_cnt at 15 stay there; the pulses still fire.

Optional Feature:
- Macro: COUNT_MONITOR_HOLD_ERR_EN.
- Defined: in TRACK, a valid sample with count==prev is treated as an illegal transition (err_pulse, err_cnt, consec_err rules apply). This is for checking a counter that must advance every clock.
- Not defined: a hold is benign, as described above.

Test Plan:
- Reset low 2 cycles, then release; count_vld=1 while the counter runs 0..15,0,1 -> single wrap_pulse the cycle after 0 is sampled following 15; wrap_cnt=1; err_cnt=0; locked=1 from the cycle after the first sample.
- In TRACK, drive count 5,6,9,10 -> err_pulse once, the cycle after 9 is sampled; err_cnt=1; consec_err back to 0 on 10; state stays 01.
- Drive 3,7,1,12 with ERR_LIMIT=3 -> three err_pulses; state=10 and locked=0 after 12; then drive 4 -> still FAULT; then 0 -> state=01 next cycle; then 1 -> no error.
- Drive 15 with count_vld=1 and clr=1 on the same cycle, then 0 -> no wrap_pulse; state=INIT after clr; 0 seeds prev; counters are 0.
- Hold count at 8 for 4 samples -> no err_pulse; rerun with COUNT_MONITOR_HOLD_ERR_EN defined -> 3 err_pulses and FAULT entered on the third.
- Force 300 wraps with WRAP_W=8 -> wrap_cnt=255 and held there; wrap_pulse still fires on every wrap; pulse reset to 0 on a mid-run reset low.

Source files
------------

// File: rtl/count_monitor_if.sv
// Bus between an up-counter (or its driver) and the count_monitor checker.
// The master side supplies the observed count and qualifiers; the slave side
// (the monitor) returns the wrap/error reporting and lock status.
interface count_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  count;
  logic              count_vld;
  logic              clr;
  logic              wrap_pulse;
  logic              err_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [3:0]        err_cnt;
  logic              locked;
  logic [1:0]        state;

  modport master (
    output count, count_vld, clr,
    input  wrap_pulse, err_pulse, wrap_cnt, err_cnt, locked, state
  );

  modport slave (
    input  count, count_vld, clr,
    output wrap_pulse, err_pulse, wrap_cnt, err_cnt, locked, state
  );
endinterface

// File: rtl/count_monitor.sv
// count_monitor: checks that an observed count advances by +1 per valid
// sample (wrapping max->0), reports wraps, sequence errors and lock status.
// Optional build macro COUNT_MONITOR_HOLD_ERR_EN: when defined, a repeated
// value in TRACK counts as an illegal transition instead of a benign stall.
//
// state  | meaning
// -------+--------------------------------------------------------------
// INIT   | waiting for first valid sample to seed the previous value
// TRACK  | locked; every valid sample is checked against prev+1
// FAULT  | ERR_LIMIT consecutive errors seen; waiting for count==0
module count_monitor #(
  parameter int WIDTH     = 4,
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 3
) (
  input logic            i_clk,
  input logic            i_reset,
  count_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_TRACK = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]  LP_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  LP_MAX       = {WIDTH{1'b1}};
  localparam logic [WRAP_W-1:0] LP_WRAP_ONE  = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        LP_ERR_LIMIT = 4'(ERR_LIMIT);
`ifdef COUNT_MONITOR_HOLD_ERR_EN
  localparam logic              LP_HOLD_OK   = 1'b0;
`else
  localparam logic              LP_HOLD_OK   = 1'b1;
`endif

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_prev, w_prev_nxt;
  logic [3:0]        r_consec, w_consec_nxt;
  logic [WRAP_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;
  logic [3:0]        r_err_cnt, w_err_cnt_nxt;
  logic              r_wrap_pulse, w_wrap_pulse_nxt;
  logic              r_err_pulse, w_err_pulse_nxt;
  logic              r_locked, w_locked_nxt;

  logic [WIDTH-1:0]  w_expected;
  logic [3:0]        w_consec_inc;
  logic              w_hold_benign;
  logic              w_at_max;

  assign w_expected    = r_prev + LP_ONE;
  assign w_consec_inc  = r_consec + 4'd1;
  assign w_hold_benign = (bus.count == r_prev) & LP_HOLD_OK;
  assign w_at_max      = (r_prev == LP_MAX);

  // State and statistics registers; reset wins over everything else.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= ST_INIT;
      r_prev       <= '0;
      r_consec     <= '0;
      r_wrap_cnt   <= '0;
      r_err_cnt    <= '0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_consec     <= w_consec_nxt;
      r_wrap_cnt   <= w_wrap_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  // Next-state and next-output decode for one sampling edge.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_consec_nxt     = r_consec;
    w_wrap_cnt_nxt   = r_wrap_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    w_wrap_pulse_nxt = 1'b0;
    w_err_pulse_nxt  = 1'b0;

    if (bus.clr) begin
      // Soft clear discards the sample taken on the same edge.
      w_state_nxt    = ST_INIT;
      w_prev_nxt     = '0;
      w_consec_nxt   = '0;
      w_wrap_cnt_nxt = '0;
      w_err_cnt_nxt  = '0;
    end else if (bus.count_vld) begin
      w_prev_nxt = bus.count;
      case (r_state)
        ST_INIT: begin
          w_state_nxt = ST_TRACK;
        end
        ST_TRACK: begin
          if (w_hold_benign) begin
            w_consec_nxt = r_consec;
          end else if (bus.count == w_expected) begin
            w_consec_nxt = '0;
            if (w_at_max) begin
              w_wrap_pulse_nxt = 1'b1;
              if (r_wrap_cnt != {WRAP_W{1'b1}}) w_wrap_cnt_nxt = r_wrap_cnt + LP_WRAP_ONE;
            end
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_consec_nxt    = w_consec_inc;
            if (r_err_cnt != 4'hF) w_err_cnt_nxt = r_err_cnt + 4'd1;
            if (w_consec_inc == LP_ERR_LIMIT) w_state_nxt = ST_FAULT;
          end
        end
        ST_FAULT: begin
          // Upstream counter restarting from zero re-establishes tracking.
          if (bus.count == '0) begin
            w_consec_nxt = '0;
            w_state_nxt  = ST_TRACK;
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end

    w_locked_nxt = (w_state_nxt == ST_TRACK);
  end

  assign bus.wrap_pulse = r_wrap_pulse;
  assign bus.err_pulse  = r_err_pulse;
  assign bus.wrap_cnt   = r_wrap_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.locked     = r_locked;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_count_monitor.sv
// Testbench for count_monitor: directed vector table, wrap saturation
// sequence, and randomized stimulus against a behavioural model.
module tb_count_monitor;

  localparam int WIDTH     = 4;
  localparam int WRAP_W    = 8;
  localparam int ERR_LIMIT = 3;
`ifdef COUNT_MONITOR_HOLD_ERR_EN
  localparam bit HOLD_ERR  = 1'b1;
`else
  localparam bit HOLD_ERR  = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) u_if ();

  count_monitor #(
    .WIDTH    (WIDTH),
    .WRAP_W   (WRAP_W),
    .ERR_LIMIT(ERR_LIMIT)
  ) u_dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference: mode 0=INIT 1=TRACK 2=FAULT.
  int m_mode, m_prev, m_consec, m_wraps, m_errs;
  bit m_wp, m_ep;

  function automatic void model_step(int c, bit v, bit cl, bit r);
    m_wp = 0;
    m_ep = 0;
    if (r || cl) begin
      m_mode = 0; m_prev = 0; m_consec = 0; m_wraps = 0; m_errs = 0;
    end else if (v) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (c == m_prev && !HOLD_ERR) begin
          // stalled upstream: nothing happens
        end else if (c == (m_prev + 1) % 16) begin
          m_consec = 0;
          if (m_prev == 15) begin
            m_wp = 1;
            m_wraps = (m_wraps + 1 > 255) ? 255 : m_wraps + 1;
          end
        end else begin
          m_ep = 1;
          m_errs = (m_errs + 1 > 15) ? 15 : m_errs + 1;
          m_consec = m_consec + 1;
          if (m_consec == ERR_LIMIT) m_mode = 2;
        end
      end else if (c == 0) begin
        m_mode = 1;
        m_consec = 0;
      end
      m_prev = c;
    end
  endfunction

  function automatic logic [31:0] pack(bit wp, bit ep, bit lk, logic [1:0] st,
                                       logic [3:0] ec, logic [7:0] wc);
    return {15'd0, wp, ep, lk, st, ec, wc};
  endfunction

  function automatic logic [31:0] dut_out();
    return pack(u_if.wrap_pulse, u_if.err_pulse, u_if.locked, u_if.state,
                u_if.err_cnt, u_if.wrap_cnt);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Apply one cycle of inputs (r=1 asserts reset), sample #1 after the edge.
  task automatic step(input int c, input bit v, input bit cl, input bit r);
    u_if.count     = 4'(c);
    u_if.count_vld = v;
    u_if.clr       = cl;
    rst_n          = ~r;
    @(posedge clk);
    #1;
    model_step(c, v, cl, r);
  endtask

  typedef struct {
    int         c;
    bit         v;
    bit         cl;
    bit         r;
    bit         wp;
    bit         ep;
    logic [1:0] st;
    logic [7:0] wc;
    logic [3:0] ec;
  } vec_t;

  vec_t vq[$];

  function automatic void add(int c, bit v, bit cl, bit r, bit wp, bit ep,
                              logic [1:0] st, logic [7:0] wc, logic [3:0] ec);
    vec_t x;
    x.c = c; x.v = v; x.cl = cl; x.r = r;
    x.wp = wp; x.ep = ep; x.st = st; x.wc = wc; x.ec = ec;
    vq.push_back(x);
  endfunction

  int n_wp;
  int lastc;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    u_if.count = '0;
    u_if.count_vld = 1'b0;
    u_if.clr = 1'b0;
    model_step(0, 0, 0, 1);

    // ---------------- directed table ----------------
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 16; i++) add(i, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 1, 0, 1, 1, 0);
    add(9, 0, 0, 0, 0, 0, 1, 1, 0);
    for (int i = 1; i < 7; i++) add(i, 1, 0, 0, 0, 0, 1, 1, 0);
    add(9, 1, 0, 0, 0, 1, 1, 1, 1);
    for (int i = 10; i < 16; i++) add(i, 1, 0, 0, 0, 0, 1, 1, 1);
    add(0, 1, 0, 0, 1, 0, 1, 2, 1);
    add(1, 1, 0, 0, 0, 0, 1, 2, 1);
    add(2, 1, 0, 0, 0, 0, 1, 2, 1);
    add(3, 1, 0, 0, 0, 0, 1, 2, 1);
    add(7, 1, 0, 0, 0, 1, 1, 2, 2);
    add(1, 1, 0, 0, 0, 1, 1, 2, 3);
    add(12, 1, 0, 0, 0, 1, 2, 2, 4);
    add(4, 1, 0, 0, 0, 0, 2, 2, 4);
    add(0, 1, 0, 0, 0, 0, 1, 2, 4);
    add(1, 1, 0, 0, 0, 0, 1, 2, 4);
    add(15, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i < 9; i++) add(i, 1, 0, 0, 0, 0, 1, 0, 0);
    if (HOLD_ERR) begin
      add(8, 1, 0, 0, 0, 1, 1, 0, 1);
      add(8, 1, 0, 0, 0, 1, 1, 0, 2);
      add(8, 1, 0, 0, 0, 1, 2, 0, 3);
    end else begin
      for (int i = 0; i < 3; i++) add(8, 1, 0, 0, 0, 0, 1, 0, 0);
    end
    add(5, 1, 1, 1, 0, 0, 0, 0, 0);
    add(3, 1, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].c, vq[i].v, vq[i].cl, vq[i].r);
      check($sformatf("vec%0d", i), dut_out(),
            pack(vq[i].wp, vq[i].ep, vq[i].st == 2'b01, vq[i].st, vq[i].ec, vq[i].wc));
    end

    // ---------------- wrap counter saturation ----------------
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    n_wp = 0;
    for (int w = 1; w <= 300; w++) begin
      for (int i = 1; i < 16; i++) begin
        step(i, 1, 0, 0);
        if (u_if.wrap_pulse) n_wp++;
      end
      step(0, 1, 0, 0);
      if (u_if.wrap_pulse) n_wp++;
      if (w == 254) check("wrap_cnt_254", 32'(u_if.wrap_cnt), 32'd254);
      if (w == 255) check("wrap_cnt_255", 32'(u_if.wrap_cnt), 32'd255);
      if (w == 256) check("wrap_cnt_sat", 32'(u_if.wrap_cnt), 32'd255);
    end
    check("wrap_cnt_300", 32'(u_if.wrap_cnt), 32'd255);
    check("wrap_pulses", 32'(n_wp), 32'd300);
    step(15, 1, 0, 0);
    step(0, 1, 0, 1);
    check("reset_midrun", dut_out(), pack(0, 0, 0, 2'b00, 4'd0, 8'd0));

    // ---------------- randomized vs model ----------------
    lastc = 0;
    for (int n = 0; n < 4000; n++) begin
      int r, c;
      bit v, cl, rs;
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = (lastc + 1) % 16;
      else if (r < 65) c = lastc;
      else if (r < 75) c = 0;
      else             c = int'($urandom_range(0, 15));
      v  = ($urandom_range(0, 99) < 85);
      cl = ($urandom_range(0, 299) == 0);
      rs = ($urandom_range(0, 399) == 0);
      step(c, v, cl, rs);
      if (v) lastc = c;
      check($sformatf("rand%0d", n), dut_out(),
            pack(m_wp, m_ep, m_mode == 1, 2'(m_mode), 4'(m_errs), 8'(m_wraps)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
